// File: rtl/confusedcore_pkg.sv
// Shared types and constants for the confusedcore I/O input bridge.
// Word/byte widths, FSM state encoding and the flash-load length clamp.
package confusedcore_pkg;

  localparam int WORD_W   = 16;
  localparam int BYTE_W   = 8;
  localparam int LOAD_MAX = 256;
  localparam int CNT_W    = 9;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    BOOT,
    LOAD_HDR,
    LOAD_DATA,
    RUN
  } io_state_t;

  // Header length field is 9 bits; anything above LOAD_MAX is clamped.
  function automatic logic [CNT_W-1:0] sat_len(logic [CNT_W-1:0] len);
    if (len > CNT_W'(LOAD_MAX)) return CNT_W'(LOAD_MAX);
    return len;
  endfunction

endpackage

// File: rtl/io_input_bridge_if.sv
// Byte-stream handshake between the off-chip host and the input bridge.
// The host is the master; the bridge consumes bytes through the slave modport.
interface io_input_bridge_if;

  confusedcore_pkg::byte_t hostData;
  logic                    hostValid;
  logic                    hostReady;

  modport master (output hostData, output hostValid, input hostReady);
  modport slave  (input hostData, input hostValid, output hostReady);

endinterface

// File: rtl/io_input_bridge_fifo.sv
// Show-ahead word FIFO; pointers carry an extra wrap bit so full and empty
// are distinguished without a separate counter.
module io_word_fifo
  import confusedcore_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  word_t din,
  input  logic  pop,
  output word_t dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  word_t       mem_q [FIFO_DEPTH];
  logic        do_push, do_pop;

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/io_input_bridge.sv
// Host byte stream -> 16-bit words -> confusedcore input port, with an optional
// boot-time flash load (length header followed by that many program words).
module io_input_bridge
  import confusedcore_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  io_input_bridge_if.slave         host,
  input  logic                     loadReq,
  input  logic                     inputWaiting,
  output logic                     inputReady,
  output word_t                    parallelIn,
  output logic                     flashEnable,
  output logic                     loading
);

  io_state_t        state_q, state_d;
  logic             phase_lo_q, phase_lo_d;
  byte_t            hi_byte_q, hi_byte_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hdr_len;
  word_t            par_q, par_d;
  logic             ir_q, ir_d;
  logic             flash_q, flash_d;
  logic             loading_q, loading_d;

  logic             host_ready, accept;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  word_t            fifo_din, fifo_dout;

  io_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    // Ready comes only from registered state, so a same-cycle pop never opens it.
    host_ready = !fifo_full && (state_q != BOOT);
    accept     = host.hostValid && host_ready;
    phase_lo_d = phase_lo_q;
    hi_byte_d  = hi_byte_q;
    fifo_push  = 1'b0;
    fifo_din   = {hi_byte_q, host.hostData};
    if (accept) begin
      if (!phase_lo_q) begin
        hi_byte_d  = host.hostData;
        phase_lo_d = 1'b1;
      end else begin
        fifo_push  = 1'b1;
        phase_lo_d = 1'b0;
      end
    end

    state_d  = state_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    ir_d     = 1'b0;
    fifo_pop = 1'b0;
    hdr_len  = sat_len(fifo_dout[CNT_W-1:0]);
    case (state_q)
      BOOT: state_d = loadReq ? LOAD_HDR : RUN;
      LOAD_HDR: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cnt_d    = hdr_len;
          state_d  = (hdr_len == '0) ? RUN : LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          par_d    = fifo_dout;
          ir_d     = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RUN;
        end
      end
      RUN: begin
        // The !ir_q guard covers the cycle where the core is still dropping inputWaiting.
        if (!fifo_empty && inputWaiting && !ir_q) begin
          fifo_pop = 1'b1;
          par_d    = fifo_dout;
          ir_d     = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
    flash_d   = (state_d == LOAD_DATA);
    loading_d = (state_d == LOAD_HDR) || (state_d == LOAD_DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      phase_lo_q <= 1'b0;
      hi_byte_q  <= '0;
      cnt_q      <= '0;
      par_q      <= '0;
      ir_q       <= 1'b0;
      flash_q    <= 1'b0;
      loading_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_lo_q <= phase_lo_d;
      hi_byte_q  <= hi_byte_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      ir_q       <= ir_d;
      flash_q    <= flash_d;
      loading_q  <= loading_d;
    end
  end

  assign host.hostReady = host_ready;
  assign inputReady     = ir_q;
  assign parallelIn     = par_q;
  assign flashEnable    = flash_q;
  assign loading        = loading_q;

endmodule

// File: tb/tb_io_input_bridge.sv
// Scoreboard bench for io_input_bridge: stimulus queues expected words, a
// negedge monitor pops and compares on every inputReady pulse.
module tb_io_input_bridge;
  import confusedcore_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  loadReq, inputWaiting, inputReady, flashEnable, loading;
  word_t parallelIn;

  io_input_bridge_if hif();

  io_input_bridge #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (rst),
    .host         (hif),
    .loadReq      (loadReq),
    .inputWaiting (inputWaiting),
    .inputReady   (inputReady),
    .parallelIn   (parallelIn),
    .flashEnable  (flashEnable),
    .loading      (loading)
  );

  always #5 clk = ~clk;

  typedef struct {
    word_t w;
    logic  fl;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  logic prev_ir = 1'b0;
  logic prev_fl = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ir = 1'b0;
      prev_fl = 1'b0;
    end else begin
      if (inputReady) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {16'h0, parallelIn}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("pulse_word", {16'h0, parallelIn}, {16'h0, e.w});
          chk("pulse_flash", {31'h0, flashEnable}, {31'h0, e.fl});
        end
        if (!flashEnable && !prev_fl)
          chk("run_pulse_spacing", {31'h0, prev_ir}, 32'h0);
      end
      prev_ir = inputReady;
      prev_fl = flashEnable;
    end
  end

  task automatic expect_word(word_t w, logic fl);
    exp_t e;
    e.w  = w;
    e.fl = fl;
    sb.push_back(e);
  endtask

  task automatic send_byte(byte_t b);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    hif.hostData  = b;
    hif.hostValid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = hif.hostReady;
      @(posedge clk);
      #1;
      n++;
    end
    hif.hostValid = 1'b0;
    if (!acc) chk("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic send_word(word_t w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_reset(logic lr);
    loadReq       = lr;
    hif.hostValid = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, sb.size(), 32'h0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_load(word_t hdr, string name);
    do_reset(1'b1);
    inputWaiting = 1'b0;
    for (int i = 0; i < LOAD_MAX; i++)
      expect_word(16'h8000 + 16'(i), (i != LOAD_MAX - 1));
    send_word(hdr);
    for (int i = 0; i < LOAD_MAX; i++) send_word(16'h8000 + 16'(i));
    wait_drain({name, "_drain"});
    chk({name, "_flash_off"}, {31'h0, flashEnable}, 32'h0);
    inputWaiting = 1'b1;
    expect_word(16'hBEEF, 1'b0);
    send_word(16'hBEEF);
    wait_drain({name, "_run_word"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    loadReq       = 1'b0;
    inputWaiting  = 1'b0;
    hif.hostValid = 1'b0;
    hif.hostData  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hostReady", {31'h0, hif.hostReady}, 32'h0);
    chk("rst_inputReady", {31'h0, inputReady}, 32'h0);
    chk("rst_parallelIn", {16'h0, parallelIn}, 32'h0);
    chk("rst_flashEnable", {31'h0, flashEnable}, 32'h0);
    chk("rst_loading", {31'h0, loading}, 32'h0);

    // 1: plain RUN delivery
    inputWaiting = 1'b1;
    rst = 1'b0;
    expect_word(16'h1234, 1'b0);
    send_word(16'h1234);
    wait_drain("t1_drain");
    chk("t1_flash", {31'h0, flashEnable}, 32'h0);

    // 2: flash load of three words, header hidden, inputWaiting ignored
    inputWaiting = 1'b0;
    do_reset(1'b1);
    @(posedge clk);
    #1;
    chk("t2_loading_hdr", {31'h0, loading}, 32'h1);
    chk("t2_flash_hdr", {31'h0, flashEnable}, 32'h0);
    expect_word(16'hAAAA, 1'b1);
    expect_word(16'hBBBB, 1'b1);
    expect_word(16'hCCCC, 1'b0);
    send_word(16'h0003);
    send_word(16'hAAAA);
    send_word(16'hBBBB);
    send_word(16'hCCCC);
    wait_drain("t2_drain");
    chk("t2_flash_end", {31'h0, flashEnable}, 32'h0);
    chk("t2_loading_end", {31'h0, loading}, 32'h0);

    // 3: FIFO fills, back-pressure, then drains in order
    do_reset(1'b0);
    inputWaiting = 1'b0;
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    send_word(16'h4444);
    @(posedge clk);
    #1;
    chk("t3_full_hostReady", {31'h0, hif.hostReady}, 32'h0);
    expect_word(16'h1111, 1'b0);
    expect_word(16'h2222, 1'b0);
    expect_word(16'h3333, 1'b0);
    expect_word(16'h4444, 1'b0);
    expect_word(16'h5555, 1'b0);
    fork
      send_word(16'h5555);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("t3_still_blocked", {31'h0, hif.hostReady}, 32'h0);
        inputWaiting = 1'b1;
      end
    join
    wait_drain("t3_drain");
    chk("t3_ready_back", {31'h0, hif.hostReady}, 32'h1);

    // 4a: zero-length header goes straight to RUN
    inputWaiting = 1'b1;
    do_reset(1'b1);
    send_word(16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_zero_loading", {31'h0, loading}, 32'h0);
    chk("t4_zero_flash", {31'h0, flashEnable}, 32'h0);
    expect_word(16'h7777, 1'b0);
    send_word(16'h7777);
    wait_drain("t4_zero_run");

    // 4b: oversized headers clamp to 256 words
    run_load(16'h0300, "t4_0300");
    run_load(16'h01FF, "t4_01ff");

    // 5: reset in the middle of a load
    do_reset(1'b1);
    inputWaiting = 1'b0;
    expect_word(16'h0101, 1'b1);
    expect_word(16'h0202, 1'b1);
    send_word(16'h0005);
    send_word(16'h0101);
    send_word(16'h0202);
    wait_drain("t5_two_words");
    chk("t5_flash_mid", {31'h0, flashEnable}, 32'h1);
    chk("t5_loading_mid", {31'h0, loading}, 32'h1);
    send_byte(8'hEE);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_inputReady", {31'h0, inputReady}, 32'h0);
    chk("t5_parallelIn", {16'h0, parallelIn}, 32'h0);
    chk("t5_flashEnable", {31'h0, flashEnable}, 32'h0);
    chk("t5_loading", {31'h0, loading}, 32'h0);
    chk("t5_hostReady", {31'h0, hif.hostReady}, 32'h0);
    rst = 1'b0;
    expect_word(16'h5A5A, 1'b0);
    send_word(16'h0001);
    send_word(16'h5A5A);
    wait_drain("t5_new_load");

    // 6: inputWaiting held high with two queued words
    do_reset(1'b0);
    inputWaiting = 1'b0;
    send_word(16'h6161);
    send_word(16'h6262);
    expect_word(16'h6161, 1'b0);
    expect_word(16'h6262, 1'b0);
    inputWaiting = 1'b1;
    wait_drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
